arbitration: RTL and testbench



---
 rtl/arb_pkg.sv | 18 +
 rtl/arb_bit_counter.sv | 35 +++
 rtl/arbitration.sv | 127 ++++++++++++
 tb/tb_arbitration.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the CAN identifier arbitration checker: identifier
// length, the default node identifier, and the arbitration state encoding.
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int unsigned ID_WIDTH = 11;
    localparam logic [ID_WIDTH-1:0] DEFAULT_ID = 11'b10101010000;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WON,
        LOST
    } arb_state_t;

endpackage

// File: rtl/arb_bit_counter.sv
// -----------------------------------------------------------------------------
// arb_bit_counter
// Bit index counter for the identifier field. Counts 0..LAST and saturates at
// LAST so it can never wrap while the field result is being held.
//
// Ports:
//   clk     - system clock, rising edge
//   clear   - synchronous clear to 0 (highest priority)
//   enable  - advance the index by one (ignored once LAST is reached)
//   index   - current bit index, 0 = identifier MSB
//   last    - high when index == LAST
// -----------------------------------------------------------------------------
module arb_bit_counter #(
    parameter int unsigned LAST = 10
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] index,
    output logic       last
);

    // The saturating guard keeps the index inside the identifier field even
    // if the controller keeps enabling after the last bit.
    always_ff @(posedge clk) begin
        if (clear) begin
            index <= 4'd0;
        end else if (enable && !last) begin
            index <= index + 4'd1;
        end
    end

    assign last = (index == 4'(LAST));

endmodule

// File: rtl/arbitration.sv
// -----------------------------------------------------------------------------
// arbitration
// CAN-style 11-bit identifier arbitration checker for one bus node. While
// arbitration_start is high it compares one received bus bit per clock, MSB
// first, against the node identifier and reports a win (all bits matched) or
// a loss (first mismatch in either direction).
//
// Ports:
//   clk                - system clock, rising edge
//   n_rst              - synchronous reset, ACTIVE HIGH despite the name
//   rxd                - bus bit for this bit time (0 dominant, 1 recessive)
//   arbitration_start  - high for the whole identifier field, low = idle/abort
//   win                - registered, arbitration won
//   loose              - registered, arbitration lost
//   lost_pos [3:0]     - only with ARB_LOST_POS_EN: index of the mismatching
//                        bit (0 = MSB), held while lost
//
// Build option: define ARB_LOST_POS_EN to add the lost_pos output.
// -----------------------------------------------------------------------------
module arbitration
    import arb_pkg::*;
#(
    parameter int unsigned ID_WIDTH = arb_pkg::ID_WIDTH,
    parameter logic [ID_WIDTH-1:0] ID = arb_pkg::DEFAULT_ID
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rxd,
    input  logic       arbitration_start,
    output logic       win,
    output logic       loose
`ifdef ARB_LOST_POS_EN
   ,output logic [3:0] lost_pos
`endif
);

    arb_state_t state;

    logic [3:0]          index;
    logic                last_bit;
    logic [ID_WIDTH-1:0] id_rev;
    logic                id_bit;
    logic                bit_match;
    logic                comparing;
    logic                count_clear;
    logic                count_enable;

    // The identifier is reversed so the bit index (0 = MSB) can select the
    // expected bit directly without a subtraction in the index path.
    always_comb begin
        id_rev = '0;
        for (int i = 0; i < int'(ID_WIDTH); i++) begin
            id_rev[i] = ID[int'(ID_WIDTH) - 1 - i];
        end
    end

    // The index is 0 in IDLE, so the same compare path handles the very first
    // bit on the start edge as well as the later bits in COMPARE.
    assign id_bit    = id_rev[index];
    assign bit_match = (rxd == id_bit);
    assign comparing = (state == IDLE) || (state == COMPARE);

    // The counter restarts on reset or whenever start is low, and advances
    // only on a matching bit that is still inside the field.
    assign count_clear  = n_rst || !arbitration_start;
    assign count_enable = arbitration_start && comparing && bit_match;

    arb_bit_counter #(
        .LAST (ID_WIDTH - 1)
    ) u_bit_counter (
        .clk    (clk),
        .clear  (count_clear),
        .enable (count_enable),
        .index  (index),
        .last   (last_bit)
    );

    // Arbitration FSM with registered outputs. Reset wins over everything,
    // a low start returns to IDLE from any state, and WON/LOST are sticky
    // for as long as start stays high.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state <= IDLE;
            win   <= 1'b0;
            loose <= 1'b0;
`ifdef ARB_LOST_POS_EN
            lost_pos <= 4'd0;
`endif
        end else if (!arbitration_start) begin
            state <= IDLE;
            win   <= 1'b0;
            loose <= 1'b0;
`ifdef ARB_LOST_POS_EN
            lost_pos <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE, COMPARE: begin
                    if (!bit_match) begin
                        state <= LOST;
                        loose <= 1'b1;
`ifdef ARB_LOST_POS_EN
                        lost_pos <= index;
`endif
                    end else if (last_bit) begin
                        state <= WON;
                        win   <= 1'b1;
                    end else begin
                        state <= COMPARE;
                    end
                end
                WON: begin
                    state <= WON;
                end
                LOST: begin
                    state <= LOST;
                end
                default: begin
                    state <= IDLE;
                    win   <= 1'b0;
                    loose <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitration.sv
// -----------------------------------------------------------------------------
// tb_arbitration
// Directed testbench for the arbitration checker with the default identifier
// 11'b10101010000. Inputs change 1 time unit after a rising edge and outputs
// are checked 1 time unit after the edge that sampled them.
// -----------------------------------------------------------------------------
module tb_arbitration;

    logic clk;
    logic n_rst;
    logic rxd;
    logic arbitration_start;
    logic win;
    logic loose;
`ifdef ARB_LOST_POS_EN
    logic [3:0] lost_pos;
`endif

    int tests_run;
    int tests_failed;

    arbitration dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .rxd               (rxd),
        .arbitration_start (arbitration_start),
        .win               (win),
        .loose             (loose)
`ifdef ARB_LOST_POS_EN
       ,.lost_pos          (lost_pos)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one set of inputs, let one rising edge sample them, then settle.
    task automatic applyStimulus(input logic rst_v, input logic start_v, input logic rxd_v);
        n_rst             = rst_v;
        arbitration_start = start_v;
        rxd               = rxd_v;
        @(posedge clk);
        #1;
    endtask

    // Compare both result outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic exp_win, input logic exp_loose);
        tests_run++;
        assert (win === exp_win && loose === exp_loose)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: win=%b loose=%b, expected win=%b loose=%b",
                   tag, win, loose, exp_win, exp_loose);
        end
    endtask

`ifdef ARB_LOST_POS_EN
    task automatic checkLostPos(input string tag, input logic [3:0] exp_pos);
        tests_run++;
        assert (lost_pos === exp_pos)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s lost_pos: got %0d, expected %0d", tag, lost_pos, exp_pos);
        end
    endtask
`endif

    // Drive an 11-bit pattern MSB first with start high, checking after every
    // bit, then one start-low clock. decide_idx is the hand-computed index of
    // the first mismatching bit; it is ignored when expect_win is set.
    task automatic runPattern(input string tag, input logic [10:0] pat,
                              input int decide_idx, input bit expect_win);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 1'b1, pat[10-i]);
            if (expect_win) begin
                checkOutput($sformatf("%s bit%0d", tag, i), (i == 10), 1'b0);
            end else begin
                checkOutput($sformatf("%s bit%0d", tag, i), 1'b0, (i >= decide_idx));
`ifdef ARB_LOST_POS_EN
                if (i >= decide_idx) checkLostPos($sformatf("%s bit%0d", tag, i), 4'(decide_idx));
`endif
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput($sformatf("%s idle", tag), 1'b0, 1'b0);
`ifdef ARB_LOST_POS_EN
        checkLostPos($sformatf("%s idle", tag), 4'd0);
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset for one edge, then release into idle.
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("reset", 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("post_reset_idle", 1'b0, 1'b0);

        // Exact identifier match wins on the 11th bit.
        runPattern("match", 11'b10101010000, 0, 1'b1);

        // Dominant-bit losses and bit-error losses at various positions.
        runPattern("loss_idx2_a", 11'b10000000000, 2, 1'b0);
        runPattern("loss_idx2_b", 11'b10001010000, 2, 1'b0);
        runPattern("biterr_idx5", 11'b10101111111, 5, 1'b0);
        runPattern("biterr_idx3", 11'b10111111111, 3, 1'b0);
        runPattern("biterr_idx8", 11'b10101010101, 8, 1'b0);
        runPattern("loss_idx4",   11'b10100000000, 4, 1'b0);
        runPattern("loss_idx0",   11'b00000000000, 0, 1'b0);

        // Back-to-back: a loss followed directly by a win must be independent.
        runPattern("b2b_loss", 11'b10111111111, 3, 1'b0);
        runPattern("b2b_win",  11'b10101010000, 0, 1'b1);

        // Abort after five matching bits, then a full match must still win,
        // showing the index restarted from the MSB.
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("abort_mid", 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort_idle", 1'b0, 1'b0);
        runPattern("after_abort", 11'b10101010000, 0, 1'b1);

        // Start held beyond the field: the win stays sticky whatever rxd does.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 1 || i == 3 || i == 5 || i == 7) ? 1'b0 : ((i == 0 || i == 2 || i == 4 || i == 6) ? 1'b1 : 1'b0));
        end
        checkOutput("hold_win_start", 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("hold_win_rx0", 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("hold_win_rx1", 1'b1, 1'b0);

        // Reset while won and start still high clears the win.
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("reset_in_won", 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Lose at index 2, then reset mid-field with start high clears loose.
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pre_reset_loss", 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("hold_loss", 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("reset_mid_field", 1'b0, 1'b0);
`ifdef ARB_LOST_POS_EN
        checkLostPos("reset_mid_field", 4'd0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("final_idle", 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
